// File: rtl/led_breath_driver_if.sv
// led_breath_driver_if
// Groups the sequencer-facing control and the LED-facing outputs of the
// breathing LED driver into one bundle.
//   en          : 1 = run, 0 = LEDs inactive and all breath state frozen
//   sel_in      : 2-bit LED select code from the sequencer
//   sel_valid   : single-cycle strobe qualifying sel_in
//   led         : registered 4-LED drive (polarity set by the driver)
//   phase       : 0 = duty ramping up, 1 = duty ramping down
//   cycle_done  : single-cycle pulse at the end of each full breath cycle
// master is the sequencer/board side, slave is the driver itself.
interface led_breath_driver_if;
  logic       en;
  logic [1:0] sel_in;
  logic       sel_valid;
  logic [3:0] led;
  logic       phase;
  logic       cycle_done;

  modport master (
    output en,
    output sel_in,
    output sel_valid,
    input  led,
    input  phase,
    input  cycle_done
  );

  modport slave (
    input  en,
    input  sel_in,
    input  sel_valid,
    output led,
    output phase,
    output cycle_done
  );
endinterface

// File: rtl/led_breath_driver.sv
// led_breath_driver
// Makes the LED chosen by the sequencer "breathe": a PWM duty that ramps
// 0 -> MAX -> 0 continuously, one duty step every STEP_DIV PWM periods.
// All other LEDs stay off.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : led_breath_driver_if.slave (en, sel_in, sel_valid -> led, phase,
//          cycle_done)
// Parameters:
//   PWM_BITS       : PWM counter/duty width, period = 2**PWM_BITS clocks
//   STEP_DIV       : PWM periods per duty step (>= 1)
//   LED_ACTIVE_LOW : 1 = LED lit when its output is 0
module led_breath_driver #(
  parameter int PWM_BITS       = 8,
  parameter int STEP_DIV       = 4,
  parameter int LED_ACTIVE_LOW = 0
) (
  input logic clk,
  input logic rst,
  led_breath_driver_if.slave bus
);

  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam int                  STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [3:0]          LED_OFF   = (LED_ACTIVE_LOW != 0) ? 4'b1111 : 4'b0000;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_next;
  logic                done_next;
  logic                cycle_done_reg;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [1:0]          sel_reg;
  logic [3:0]          led_reg;
  logic [3:0]          led_raw;
  logic                period_end;
  logic                step_tick;
  logic                sel_change;
  logic                pwm_on;

  // A strobe carrying the already-selected code is ignored so the breath
  // is not restarted needlessly. en already gates period_end, so step_tick
  // can never fire while the driver is disabled.
  assign sel_change = bus.sel_valid && (bus.sel_in != sel_reg);
  assign period_end = (pwm_cnt == MAX) && bus.en;
  assign step_tick  = period_end && (step_cnt == STEP_LAST);
  assign pwm_on     = (pwm_cnt < duty);

  // PWM period counter and the divider that paces duty steps. A selection
  // change restarts both so the new LED begins a clean period.
  always_ff @(posedge clk) begin
    if (rst || sel_change) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else if (bus.en) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (period_end) begin
        step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      end
    end
  end

  // Selected LED index, taken from any strobe that changes it, even while
  // the driver is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg <= '0;
    end else if (sel_change) begin
      sel_reg <= bus.sel_in;
    end
  end

  // Duty FSM state register. A selection change has priority over a
  // coincident step and restarts the ramp from zero.
  always_ff @(posedge clk) begin
    if (rst || sel_change) begin
      state          <= UP;
      duty           <= '0;
      cycle_done_reg <= 1'b0;
    end else begin
      state          <= state_next;
      duty           <= duty_next;
      cycle_done_reg <= done_next;
    end
  end

  // Next duty/state on a step. The turnarounds skip the endpoint value so
  // MAX and 0 are each held for only one step, giving 2*MAX steps per breath.
  always_comb begin
    state_next = state;
    duty_next  = duty;
    done_next  = 1'b0;
    if (step_tick) begin
      case (state)
        UP: begin
          if (duty == MAX) begin
            state_next = DOWN;
            duty_next  = MAX - 1'b1;
          end else begin
            duty_next = duty + 1'b1;
          end
        end
        DOWN: begin
          if (duty == '0) begin
            state_next = UP;
            duty_next  = {{(PWM_BITS-1){1'b0}}, 1'b1};
            done_next  = 1'b1;
          end else begin
            duty_next = duty - 1'b1;
          end
        end
        default: begin
          state_next = UP;
          duty_next  = '0;
        end
      endcase
    end
  end

  // One-hot lit pattern for the selected LED, before polarity is applied.
  always_comb begin
    led_raw = '0;
    if (bus.en && pwm_on) begin
      led_raw[sel_reg] = 1'b1;
    end
  end

  // Registered LED drive; XOR with the off pattern applies polarity.
  always_ff @(posedge clk) begin
    if (rst || sel_change) begin
      led_reg <= LED_OFF;
    end else begin
      led_reg <= led_raw ^ LED_OFF;
    end
  end

  // FSM outputs.
  always_comb begin
    bus.led        = led_reg;
    bus.phase      = (state == DOWN);
    bus.cycle_done = cycle_done_reg;
  end

endmodule

// File: tb/tb_led_breath_driver.sv
// tb_led_breath_driver
// Drives an active-high and an active-low led_breath_driver (PWM_BITS=4,
// STEP_DIV=2) with identical stimulus. Expected outputs come from a
// closed-form breath timeline: with k enabled edges since the last restart,
// duty before edge k is tri(k/32), where tri() is the 0..15..0 triangle with
// a period of 30 steps.
module tb_led_breath_driver;

  typedef struct {
    logic [3:0] led;
    logic       phase;
    logic       cycle_done;
  } expect_t;

  logic clk = 1'b0;
  logic rst;

  led_breath_driver_if bus_hi ();
  led_breath_driver_if bus_lo ();

  expect_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      kn;
  logic [1:0] exp_sel;
  int      done_pulses = 0;

  assign bus_lo.en        = bus_hi.en;
  assign bus_lo.sel_in    = bus_hi.sel_in;
  assign bus_lo.sel_valid = bus_hi.sel_valid;

  led_breath_driver #(.PWM_BITS(4), .STEP_DIV(2), .LED_ACTIVE_LOW(0)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi)
  );

  led_breath_driver #(.PWM_BITS(4), .STEP_DIV(2), .LED_ACTIVE_LOW(1)) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (bus_lo)
  );

  always #5 clk = ~clk;

  // Duty reached after s steps.
  function automatic int tri_duty(input int s);
    int t;
    t = s % 30;
    return (t <= 15) ? t : 30 - t;
  endfunction

  // Phase after s steps: down from step 16 of each cycle until the
  // turnaround back up at step 31, 61, ...
  function automatic logic tri_phase(input int s);
    int t;
    t = s % 30;
    return (t >= 16) || (t == 0 && s > 0);
  endfunction

  // Drives one cycle of inputs at the falling edge and queues what the
  // outputs must be after the following rising edge.
  task automatic apply_stimulus(input logic r, input logic e, input logic sv,
                                input logic [1:0] si);
    expect_t x;
    @(negedge clk);
    rst              = r;
    bus_hi.en        = e;
    bus_hi.sel_valid = sv;
    bus_hi.sel_in    = si;
    x.led        = 4'b0000;
    x.phase      = 1'b0;
    x.cycle_done = 1'b0;
    if (r) begin
      kn      = 0;
      exp_sel = 2'd0;
    end else if (sv && si != exp_sel) begin
      kn      = 0;
      exp_sel = si;
    end else if (!e) begin
      x.phase = tri_phase(kn / 32);
    end else begin
      if ((kn % 16) < tri_duty(kn / 32)) begin
        x.led[exp_sel] = 1'b1;
      end
      x.phase      = tri_phase((kn + 1) / 32);
      x.cycle_done = ((kn + 1) % 32 == 0) && (((kn + 1) / 32) % 30 == 1)
                     && ((kn + 1) / 32 > 1);
      kn++;
    end
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, e, 1'b0, 2'd0);
    end
  endtask

  task automatic check_output(input string name, input logic [3:0] actual,
                              input logic [3:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%b required=%b", name, $time,
               actual, required);
    end
  endtask

  // Monitor: every rising edge that has a queued expectation is checked
  // shortly after the edge on both polarities.
  initial begin : monitor
    expect_t m;
    forever begin
      @(posedge clk);
      #1;
      if (bus_hi.cycle_done === 1'b1) begin
        done_pulses++;
      end
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        check_output("led_hi", bus_hi.led, m.led);
        check_output("led_lo", bus_lo.led, ~m.led);
        check_output("phase_hi", {3'b000, bus_hi.phase}, {3'b000, m.phase});
        check_output("phase_lo", {3'b000, bus_lo.phase}, {3'b000, m.phase});
        check_output("cycle_done_hi", {3'b000, bus_hi.cycle_done},
                     {3'b000, m.cycle_done});
        check_output("cycle_done_lo", {3'b000, bus_lo.cycle_done},
                     {3'b000, m.cycle_done});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int drain;
    rst              = 1'b1;
    bus_hi.en        = 1'b0;
    bus_hi.sel_valid = 1'b0;
    bus_hi.sel_in    = 2'd0;
    kn               = 0;
    exp_sel          = 2'd0;

    $display("[TB] reset");
    repeat (10) apply_stimulus(1'b1, 1'b1, 1'b0, 2'd0);

    $display("[TB] full breath cycle on LED 0, stop at duty 9");
    run(1260, 1'b1);

    $display("[TB] select LED 2 at duty 9");
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'd2);
    run(197, 1'b1);

    $display("[TB] hold at duty 6 for 100 clocks");
    run(50, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 2'd2);
    run(49, 1'b0);
    run(64, 1'b1);

    $display("[TB] reselect LED 2 while running");
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'd2);
    run(20, 1'b1);

    $display("[TB] select LED 3 while disabled");
    apply_stimulus(1'b0, 1'b0, 1'b1, 2'd3);
    run(5, 1'b0);
    run(600, 1'b1);

    $display("[TB] reset during ramp down");
    apply_stimulus(1'b1, 1'b1, 1'b0, 2'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 2'd0);
    run(40, 1'b1);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    check_output("cycle_done_count", done_pulses[3:0], 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_breath_driver.md
Name: led_breath_driver

Overview:
- Output stage that consumes the 2-bit LED-select code produced by the LED sequencer.
- Drives a 4-LED bank. The selected LED "breathes": its PWM duty ramps up then down continuously. All other LEDs are off.
- Sits between the sequencer and the board LED pins.

Parameters:
PWM_BITS, 8, width of PWM counter and duty; PWM period = 2^PWM_BITS clocks; MAX = 2^PWM_BITS-1
STEP_DIV, 4, number of PWM periods per duty step (>=1)
LED_ACTIVE_LOW, 0, 1 = invert led outputs (LED on = 0)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  1 = run; 0 = LEDs inactive, all counters/duty hold
sel_in  input  2  LED select code from sequencer
sel_valid  input  1  1-cycle strobe qualifying sel_in
led  output  4  LED drive, registered
phase  output  1  0 = ramping up, 1 = ramping down
cycle_done  output  1  1-cycle pulse at end of each full breath cycle

Behaviour:
- One clock domain. Reset is synchronous and active-high (clk, rst).
- Reset values: pwm_cnt=0, step_cnt=0, duty=0, state UP (phase=0), sel_reg=0, cycle_done=0. led = 4'b0000, or 4'b1111 if LED_ACTIVE_LOW=1.
- pwm_cnt:
  - PWM_BITS-bit counter, increments each clock while en=1, wraps MAX->0.
  - period_end = (pwm_cnt==MAX) && en.
- step_cnt:
  - Counts period_end events 0..STEP_DIV-1.
  - step_tick = period_end && step_cnt==STEP_DIV-1; step_cnt then returns to 0.
- Duty FSM, updated only on step_tick:
  - UP: if duty==MAX -> state DOWN, duty=MAX-1; else duty+1.
  - DOWN: if duty==0 -> state UP, duty=1, cycle_done=1 for that cycle; else duty-1.
  - Full breath cycle = 2*MAX steps.
- pwm_on = (pwm_cnt < duty), unsigned compare. duty=0 gives always off; duty=MAX gives MAX of every 2^PWM_BITS clocks on.
- led, registered with 1-cycle latency from pwm_cnt/duty:
  - led[i] <= en && (i==sel_reg) && pwm_on, XOR LED_ACTIVE_LOW.
  - Exactly zero or one LED active at any time.
- Selection:
  - sel_valid=1 with sel_in != sel_reg: next cycle sel_reg=sel_in, duty=0, state UP, pwm_cnt=0, step_cnt=0, and led all inactive. The new LED then restarts its breath from 0.
  - sel_valid=1 with sel_in == sel_reg: no effect, breath continues.
  - Selection change takes priority over a coincident step_tick.
- en=0:
  - led goes inactive on the next clock.
  - pwm_cnt, step_cnt, duty, state hold; no cycle_done.
  - sel_valid is still accepted while en=0.
  - en 0->1 resumes from the held values.
- rst asserted mid-operation overrides everything: all state returns to reset values on the next edge.
- phase = state (DOWN=1).

Test Plan:
All tests use PWM_BITS=4, STEP_DIV=2: period 16 clocks, step every 32 clocks, MAX=15.
- Reset: rst=1 for 10 clocks, then 0, en=1 -> during rst led=0000, phase=0, cycle_done=0. Clocks 0-31 after release: led=0000 (duty 0).
- Ramp: after step 1 (duty=1), led[0] high exactly 1 clock per 16-clock period, others 0. At step 8, led[0] high 8 of 16 clocks, in clocks following pwm_cnt=0..7 (1-cycle latency).
- Turnaround/cycle: step 15 -> duty=15, phase=0. Step 16 -> duty=14, phase=1. Step 30 -> duty=0. Step 31 -> duty=1, phase=0, cycle_done high exactly 1 clock.
- Selection change: at duty=9, pulse sel_valid with sel_in=2 -> next clock duty=0, phase=0, led=0000; then led[2] breathes from duty 1, led[0] stays 0. Pulse sel_valid with sel_in=2 again -> no restart, duty unchanged.
- Enable/hold: at duty=6 drive en=0 for 100 clocks -> led=0000 from the next clock, duty stays 6. en=1 -> pulsing resumes at 6/16.
- Polarity and mid-run reset: LED_ACTIVE_LOW=1 -> reset gives led=1111 and the selected LED pulses low. rst=1 during phase=1 -> next clock duty=0, phase=0, led=1111.
